// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared state encoding and one-hot helper for decoder_scan.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hold = 2'd1;
    localparam logic [1:0] c_st_scan = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_HOLD = c_st_hold,
        ST_SCAN = c_st_scan
    } state_t;

    // Out-of-range indices decode to all zeros so d can never carry a stray bit.
    function automatic logic [63:0] onehot(input int index, input int width);
        logic [63:0] v;
        v = '0;
        if ((index >= 0) && (index < width) && (index < 64)) begin
            v = 64'd1 << index;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module      : decoder_dwell_cnt
// Description : Dwell down-counter; o_tick is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_dwell_cnt
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_run,
    output logic               o_tick
);

    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : Registered one-hot decoder with handshake select and optional
//               auto-scan (enabled by macro DECODER_SCAN_SCAN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  scan_start,
    input  logic                  scan_stop,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] d,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy
);

    localparam int c_n_out = 2 ** SEL_W;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_n_out-1:0]   r_d;
    logic [c_n_out-1:0]   w_d_nxt;
    logic [SEL_W-1:0]     r_cur_sel;
    logic [SEL_W-1:0]     w_cur_sel_nxt;
    logic [SEL_W-1:0]     w_adv_idx;
    logic                 w_accept;
    logic                 w_scan_go;
    logic                 w_scan_stop;
    logic                 w_advance;

`ifdef DECODER_SCAN_SCAN_EN
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   w_cnt_val;
    logic                 w_cnt_load;
    logic                 w_tick;

    // A simultaneous stop wins over start, which outside SCAN means nothing happens.
    assign w_scan_go   = en & scan_start & ~scan_stop & (r_state != ST_SCAN);
    assign w_scan_stop = en & scan_stop & (r_state == ST_SCAN);
    assign w_advance   = en & ~scan_stop & (r_state == ST_SCAN) & w_tick;
    assign w_cnt_load  = w_scan_go | w_advance;
    assign w_cnt_val   = w_scan_go ? dwell : r_dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
        end else if (w_scan_go) begin
            r_dwell <= dwell;
        end
    end

    decoder_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_run      (r_state == ST_SCAN),
        .o_tick     (w_tick)
    );

    assign busy = (r_state == ST_SCAN);
`else
    logic w_unused_scan;

    assign w_unused_scan = ^{scan_start, scan_stop, dwell};
    assign w_scan_go     = 1'b0;
    assign w_scan_stop   = 1'b0;
    assign w_advance     = 1'b0;
    assign busy          = 1'b0;
`endif

    // rst_n gates ready directly so it reads low for the whole reset window.
    assign sel_ready = rst_n & en & (r_state != ST_SCAN) & ~w_scan_go;
    assign w_accept  = sel_valid & sel_ready;
    assign w_adv_idx = r_cur_sel + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_d_nxt       = r_d;
        w_cur_sel_nxt = r_cur_sel;
        if (!en || w_scan_stop) begin
            w_state_nxt   = ST_IDLE;
            w_d_nxt       = '0;
            w_cur_sel_nxt = '0;
        end else if (w_scan_go) begin
            w_state_nxt   = ST_SCAN;
            w_d_nxt       = c_n_out'(onehot(0, c_n_out));
            w_cur_sel_nxt = '0;
        end else if (w_advance) begin
            w_d_nxt       = c_n_out'(onehot(int'(w_adv_idx), c_n_out));
            w_cur_sel_nxt = w_adv_idx;
        end else if (w_accept) begin
            w_state_nxt   = ST_HOLD;
            w_d_nxt       = c_n_out'(onehot(int'(sel), c_n_out));
            w_cur_sel_nxt = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_d       <= '0;
            r_cur_sel <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_d       <= w_d_nxt;
            r_cur_sel <= w_cur_sel_nxt;
        end
    end

    assign d       = r_d;
    assign cur_sel = r_cur_sel;

endmodule
`default_nettype wire
